// File: rtl/control_unit.sv
// K&S control unit: Moore FSM that sequences fetch, decode and execute for data_path.
// The decoded-instruction type lives in k_and_s_pkg so data_path and the bench can share it.
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
  } decoded_instruction_type;
endpackage

module control_unit
  import k_and_s_pkg::*;
#(
  parameter int RAM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt
);
  localparam logic [2:0] FETCH   = 3'd0;
  localparam logic [2:0] DECODE  = 3'd1;
  localparam logic [2:0] LOAD    = 3'd2;
  localparam logic [2:0] STORE   = 3'd3;
  localparam logic [2:0] EXEC_RD = 3'd4;
  localparam logic [2:0] EXEC_WR = 3'd5;
  localparam logic [2:0] BRANCH  = 3'd6;
  localparam logic [2:0] HALT    = 3'd7;

  logic [2:0]              state, state_nxt;
  logic [2:0]              wait_cnt;
  decoded_instruction_type op_reg;
  logic                    last, taken;
  logic [1:0]              alu_op;
  logic                    unused_carry;

  // No instruction branches on carry; kept on the port for datapath symmetry.
  assign unused_carry = unsigned_overflow;
  assign last         = (wait_cnt == 3'(RAM_LATENCY - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      wait_cnt <= '0;
      op_reg   <= I_NOP;
    end else begin
      state <= state_nxt;
      if ((state == FETCH || state == LOAD) && !last) wait_cnt <= wait_cnt + 3'd1;
      else                                            wait_cnt <= '0;
      if (state == DECODE) op_reg <= decoded_instruction;
    end
  end

  always_comb begin
    alu_op = 2'b00;
    case (op_reg)
      I_ADD:   alu_op = 2'b01;
      I_SUB:   alu_op = 2'b10;
      I_AND:   alu_op = 2'b11;
      default: alu_op = 2'b00;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (op_reg)
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = zero_op;
      I_BNEG:   taken = neg_op;
      I_BNNEG:  taken = !neg_op;
      I_BOV:    taken = signed_overflow;
      I_BNOV:   taken = !signed_overflow;
      default:  taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:  if (last) state_nxt = DECODE;
      DECODE: begin
        case (decoded_instruction)
          I_LOAD:                               state_nxt = LOAD;
          I_STORE:                              state_nxt = STORE;
          I_ADD, I_SUB, I_AND, I_OR, I_MOVE:    state_nxt = EXEC_RD;
          I_BRANCH, I_BZERO, I_BNEG, I_BNNEG,
          I_BOV, I_BNOV:                        state_nxt = BRANCH;
          I_HALT:                               state_nxt = HALT;
          default:                              state_nxt = FETCH;
        endcase
      end
      LOAD:    if (last) state_nxt = FETCH;
      STORE:   state_nxt = FETCH;
      EXEC_RD: state_nxt = EXEC_WR;
      EXEC_WR: state_nxt = FETCH;
      BRANCH:  state_nxt = FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  // Outputs are blanked while rst is high so no strobe escapes during a reset window.
  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          ir_enable = last;
          pc_enable = last;
        end
        LOAD: begin
          addr_sel         = 1'b1;
          write_reg_enable = last;
        end
        STORE: begin
          addr_sel         = 1'b1;
          ram_write_enable = 1'b1;
        end
        EXEC_RD: begin
          operation = alu_op;
          c_sel     = 1'b1;
        end
        EXEC_WR: begin
          operation        = alu_op;
          c_sel            = 1'b1;
          write_reg_enable = 1'b1;
          flags_reg_enable = (op_reg != I_MOVE);
        end
        BRANCH: begin
          branch    = 1'b1;
          pc_enable = taken;
        end
        HALT:    halt = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues per-cycle expected outputs, monitors compare.
module tb_control_unit;
  import k_and_s_pkg::*;

  localparam logic [10:0] Z    = 11'h000;
  localparam logic [10:0] B    = 11'h400;
  localparam logic [10:0] PC   = 11'h200;
  localparam logic [10:0] IR   = 11'h100;
  localparam logic [10:0] AS   = 11'h080;
  localparam logic [10:0] CS   = 11'h040;
  localparam logic [10:0] OADD = 11'h010;
  localparam logic [10:0] OSUB = 11'h020;
  localparam logic [10:0] OAND = 11'h030;
  localparam logic [10:0] WR   = 11'h008;
  localparam logic [10:0] FL   = 11'h004;
  localparam logic [10:0] RW   = 11'h002;
  localparam logic [10:0] HL   = 11'h001;

  typedef struct { logic [10:0] e; string nm; } exp_t;
  typedef struct { decoded_instruction_type i; logic [10:0] rd; logic [10:0] wr; string nm; } alu_t;
  typedef struct { decoded_instruction_type i; logic [3:0] f; logic tk; } br_t;

  logic clk = 1'b0;
  logic rst1, rst3;
  decoded_instruction_type instr1, instr3;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;

  logic b1, pce1, ire1, as1, cs1, wre1, fre1, rwe1, hl1;
  logic b3, pce3, ire3, as3, cs3, wre3, fre3, rwe3, hl3;
  logic [1:0] op1, op3;
  logic [10:0] act1, act3;

  exp_t q1[$];
  exp_t q3[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control_unit #(.RAM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .decoded_instruction(instr1),
    .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow),
    .branch(b1), .pc_enable(pce1), .ir_enable(ire1), .addr_sel(as1), .c_sel(cs1),
    .operation(op1), .write_reg_enable(wre1), .flags_reg_enable(fre1),
    .ram_write_enable(rwe1), .halt(hl1)
  );

  control_unit #(.RAM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst3), .decoded_instruction(instr3),
    .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow),
    .branch(b3), .pc_enable(pce3), .ir_enable(ire3), .addr_sel(as3), .c_sel(cs3),
    .operation(op3), .write_reg_enable(wre3), .flags_reg_enable(fre3),
    .ram_write_enable(rwe3), .halt(hl3)
  );

  assign act1 = {b1, pce1, ire1, as1, cs1, op1, wre1, fre1, rwe1, hl1};
  assign act3 = {b3, pce3, ire3, as3, cs3, op3, wre3, fre3, rwe3, hl3};

  always @(negedge clk) begin
    if (q1.size() > 0) begin
      exp_t x;
      x = q1.pop_front();
      total++;
      if (act1 !== x.e) begin
        bad++;
        $display("FAIL L1 %s: got %b want %b (t=%0t)", x.nm, act1, x.e, $time);
      end
    end
    if (q3.size() > 0) begin
      exp_t x;
      x = q3.pop_front();
      total++;
      if (act3 !== x.e) begin
        bad++;
        $display("FAIL L3 %s: got %b want %b (t=%0t)", x.nm, act3, x.e, $time);
      end
    end
  end

  // Expected vector describes the outputs of the cycle that starts at the last posedge.
  task automatic cyc1(input logic [10:0] e, input string nm);
    q1.push_back('{e, nm});
    @(posedge clk); #1;
  endtask

  task automatic cyc3(input logic [10:0] e, input string nm);
    q3.push_back('{e, nm});
    @(posedge clk); #1;
  endtask

  task automatic fetch_dec1(input decoded_instruction_type i);
    instr1 = i;
    cyc1(PC | IR, "fetch");
    cyc1(Z, "decode");
  endtask

  alu_t alv[5] = '{
    '{I_ADD,  CS | OADD, CS | OADD | WR | FL, "add"},
    '{I_SUB,  CS | OSUB, CS | OSUB | WR | FL, "sub"},
    '{I_AND,  CS | OAND, CS | OAND | WR | FL, "and"},
    '{I_OR,   CS,        CS | WR | FL,        "or"},
    '{I_MOVE, CS,        CS | WR,             "move"}
  };

  // flags packed as {zero, neg, signed_ovf, unsigned_ovf}
  br_t brv[12] = '{
    '{I_BRANCH, 4'b0000, 1'b1},
    '{I_BZERO,  4'b1000, 1'b1},
    '{I_BZERO,  4'b0111, 1'b0},
    '{I_BNEG,   4'b0100, 1'b1},
    '{I_BNEG,   4'b1011, 1'b0},
    '{I_BNNEG,  4'b0000, 1'b1},
    '{I_BNNEG,  4'b0100, 1'b0},
    '{I_BOV,    4'b0010, 1'b1},
    '{I_BOV,    4'b1101, 1'b0},
    '{I_BNOV,   4'b0001, 1'b1},
    '{I_BNOV,   4'b0010, 1'b0},
    '{I_BRANCH, 4'b1111, 1'b1}
  };

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    decoded_instruction_type unk;
    unk    = decoded_instruction_type'(4'hF);
    rst1   = 1'b1;
    rst3   = 1'b1;
    instr1 = I_NOP;
    instr3 = I_NOP;
    {zero_op, neg_op, signed_overflow, unsigned_overflow} = 4'b0000;
    @(posedge clk); #1;
    cyc1(Z, "reset");
    cyc1(Z, "reset");
    rst1 = 1'b0;

    fetch_dec1(I_ADD);
    cyc1(CS | OADD, "add_rd");
    cyc1(CS | OADD | WR | FL, "add_wr");

    // reset held for 3 cycles starting in EXEC_WR
    fetch_dec1(I_SUB);
    cyc1(CS | OSUB, "sub_rd");
    rst1 = 1'b1;
    cyc1(Z, "rst_in_wr");
    cyc1(Z, "rst_hold");
    cyc1(Z, "rst_hold");
    rst1 = 1'b0;

    foreach (alv[k]) begin
      fetch_dec1(alv[k].i);
      cyc1(alv[k].rd, {alv[k].nm, "_rd"});
      cyc1(alv[k].wr, {alv[k].nm, "_wr"});
    end

    fetch_dec1(I_LOAD);
    cyc1(AS | WR, "load_l1");
    fetch_dec1(I_STORE);
    cyc1(AS | RW, "store");
    fetch_dec1(I_NOP);
    fetch_dec1(unk);

    foreach (brv[k]) begin
      {zero_op, neg_op, signed_overflow, unsigned_overflow} = brv[k].f;
      fetch_dec1(brv[k].i);
      cyc1(B | (brv[k].tk ? PC : Z), $sformatf("br%0d", k));
    end

    fetch_dec1(I_HALT);
    repeat (100) cyc1(HL, "halt");
    rst1 = 1'b1;
    cyc1(Z, "halt_rst");
    rst1   = 1'b0;
    instr1 = I_NOP;
    cyc1(PC | IR, "resume");

    // RAM_LATENCY = 3 instance: LOAD takes 7 cycles, ADD takes 6
    rst3   = 1'b0;
    instr3 = I_LOAD;
    cyc3(Z, "f3_0");
    cyc3(Z, "f3_1");
    cyc3(PC | IR, "f3_2");
    cyc3(Z, "dec3");
    cyc3(AS, "ld3_0");
    cyc3(AS, "ld3_1");
    cyc3(AS | WR, "ld3_2");
    instr3 = I_ADD;
    cyc3(Z, "f3_0");
    cyc3(Z, "f3_1");
    cyc3(PC | IR, "f3_2");
    cyc3(Z, "dec3");
    cyc3(CS | OADD, "add3_rd");
    cyc3(CS | OADD | WR | FL, "add3_wr");
    cyc3(Z, "f3_next");

    @(posedge clk); #1;
    total++;
    if (q1.size() + q3.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q1.size() + q3.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
